// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
package hazard_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MW_IDLE,
        MW_WAIT,
        MW_ERROR
    } mem_wait_state_e;

    // Newest producer (Memory stage) wins over Writeback.
    function automatic fwd_sel_e fwd_select(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] rd_m,
        input logic                      we_m,
        input logic [REG_ADDR_WIDTH-1:0] rd_w,
        input logic                      we_w
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (we_m && rd_m != '0 && rd_m == rs)
            sel = FWD_M;
        else if (we_w && rd_w != '0 && rd_w == rs)
            sel = FWD_W;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_mem_wait_fsm.sv
// Data-memory wait-state FSM with timeout watchdog; ERROR is sticky until rst.
module hazard_mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req_m_i,
    input  logic mem_ready_i,
    output logic freeze,
    output logic mem_busy_o,
    output logic mem_timeout_o
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    mem_wait_state_e state, state_next;
    logic [CW-1:0]   wait_cnt, wait_cnt_next;
    logic            pending;

    assign pending = mem_req_m_i && !mem_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MW_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        unique case (state)
            MW_IDLE: begin
                if (pending) begin
                    state_next    = MW_WAIT;
                    wait_cnt_next = CW'(1);
                end
            end
            MW_WAIT: begin
                // Ready or a withdrawn request both end the wait.
                if (!pending) begin
                    state_next    = MW_IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt == CW'(MEM_TIMEOUT)) begin
                    state_next = MW_ERROR;
                end else begin
                    wait_cnt_next = wait_cnt + CW'(1);
                end
            end
            MW_ERROR: begin
                state_next = MW_ERROR;
            end
            default: begin
                state_next    = MW_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    assign freeze        = pending || (state == MW_ERROR);
    assign mem_busy_o    = (state != MW_IDLE);
    assign mem_timeout_o = (state == MW_ERROR);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, flush, memory freeze.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_d_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_d_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_e_i,
    input  logic [1:0]                result_src_e_i,
    input  logic                      pc_src_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_m_i,
    input  logic                      reg_write_m_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_w_i,
    input  logic                      reg_write_w_i,
    input  logic                      mem_req_m_i,
    input  logic                      mem_ready_i,
    output logic [1:0]                forward_a_e_o,
    output logic [1:0]                forward_b_e_o,
    output logic                      stall_f_o,
    output logic                      stall_d_o,
    output logic                      stall_e_o,
    output logic                      stall_m_o,
    output logic                      stall_w_o,
    output logic                      flush_d_o,
    output logic                      flush_e_o,
    output logic                      mem_busy_o,
    output logic                      mem_timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      perf_lw_stall_o,
    output logic [CNT_WIDTH-1:0]      perf_flush_o,
    output logic [CNT_WIDTH-1:0]      perf_mem_wait_o
`endif
);

    logic freeze;
    logic lw_stall;

    hazard_mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait (
        .clk          (clk),
        .rst          (rst),
        .mem_req_m_i  (mem_req_m_i),
        .mem_ready_i  (mem_ready_i),
        .freeze       (freeze),
        .mem_busy_o   (mem_busy_o),
        .mem_timeout_o(mem_timeout_o)
    );

    assign forward_a_e_o = fwd_select(rs1_addr_e_i, rd_addr_m_i,
                                      reg_write_m_i, rd_addr_w_i,
                                      reg_write_w_i);
    assign forward_b_e_o = fwd_select(rs2_addr_e_i, rd_addr_m_i,
                                      reg_write_m_i, rd_addr_w_i,
                                      reg_write_w_i);

    // A taken branch kills the dependent Decode instruction anyway.
    assign lw_stall = (result_src_e_i == RESULT_SRC_MEM)
                   && (rd_addr_e_i != '0)
                   && (rd_addr_e_i == rs1_addr_d_i
                       || rd_addr_e_i == rs2_addr_d_i)
                   && !pc_src_e_i;

    // ID/EX gives flush priority over stall, so flushes are masked in freeze.
    always_comb begin
        stall_f_o = lw_stall;
        stall_d_o = lw_stall;
        stall_e_o = 1'b0;
        stall_m_o = 1'b0;
        stall_w_o = 1'b0;
        flush_d_o = pc_src_e_i;
        flush_e_o = lw_stall | pc_src_e_i;
        if (freeze) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            stall_m_o = 1'b1;
            stall_w_o = 1'b1;
            flush_d_o = 1'b0;
            flush_e_o = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lw_stall_o <= '0;
            perf_flush_o    <= '0;
            perf_mem_wait_o <= '0;
        end else begin
            if (lw_stall && !freeze)
                perf_lw_stall_o <= perf_lw_stall_o + CNT_WIDTH'(1);
            if (pc_src_e_i && !freeze)
                perf_flush_o <= perf_flush_o + CNT_WIDTH'(1);
            if (freeze)
                perf_mem_wait_o <= perf_mem_wait_o + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32 core; it is the source of every stall/flush strobe consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generates forwarding selects for Execute, load-use stalls and branch/jump flushes.
- Runs a wait-state FSM that freezes the whole pipeline while the data memory is not ready, with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 64, memory wait cycles tolerated before declaring a timeout error (must be >= 2).
- CNT_WIDTH, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- rs1_addr_d_i  input  REG_ADDR_WIDTH  Decode rs1 address
- rs2_addr_d_i  input  REG_ADDR_WIDTH  Decode rs2 address
- rs1_addr_e_i  input  REG_ADDR_WIDTH  Execute rs1 address
- rs2_addr_e_i  input  REG_ADDR_WIDTH  Execute rs2 address
- rd_addr_e_i  input  REG_ADDR_WIDTH  Execute destination
- result_src_e_i  input  2  Execute result source; RESULT_SRC_MEM (2'b01) marks a load
- pc_src_e_i  input  1  taken branch or jump resolved in Execute
- rd_addr_m_i  input  REG_ADDR_WIDTH  Memory-stage destination
- reg_write_m_i  input  1  Memory-stage write enable
- rd_addr_w_i  input  REG_ADDR_WIDTH  Writeback destination
- reg_write_w_i  input  1  Writeback write enable
- mem_req_m_i  input  1  Memory stage is issuing a data access
- mem_ready_i  input  1  data memory accepts/completes the access this cycle
- forward_a_e_o  output  2  ALU operand A select: 00 register file, 01 W, 10 M
- forward_b_e_o  output  2  ALU operand B select, same encoding
- stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o  output  1 each  per-stage hold
- flush_d_o, flush_e_o  output  1 each  bubble insert
- mem_busy_o  output  1  FSM in WAIT or ERROR
- mem_timeout_o  output  1  sticky timeout error

Behaviour:
Forwarding (combinational):
- Operand A is 10 if reg_write_m_i and rd_addr_m_i != 0 and rd_addr_m_i == rs1_addr_e_i.
- Otherwise 01 if the same test passes for W.
- Otherwise 00.
- M has priority over W. Operand B uses rs2_addr_e_i the same way.

lw_stall:
- Asserted when result_src_e_i == 2'b01, rd_addr_e_i != 0, rd_addr_e_i matches rs1_addr_d_i or rs2_addr_d_i, and pc_src_e_i == 0.
- A taken branch kills the dependent Decode instruction, so it suppresses the stall.

freeze:
- Asserted when (mem_req_m_i and !mem_ready_i) or state == ERROR.

Output equations:
- When freeze: all five stall outputs are 1 and flush_d_o/flush_e_o are forced to 0, because the ID/EX register gives flush priority over stall.
- When not freeze:
  - stall_f_o = stall_d_o = lw_stall
  - stall_e_o = stall_m_o = stall_w_o = 0
  - flush_d_o = pc_src_e_i
  - flush_e_o = lw_stall | pc_src_e_i

FSM (registered), states IDLE, WAIT, ERROR; wait_cnt is clog2(MEM_TIMEOUT+1) bits:
- IDLE -> WAIT when mem_req_m_i & !mem_ready_i; wait_cnt <= 1.
- WAIT -> IDLE when mem_ready_i; wait_cnt <= 0. WAIT is held while the request stays pending.
- In WAIT, wait_cnt increments each not-ready cycle. When wait_cnt == MEM_TIMEOUT and not ready, go to ERROR.
- If mem_req_m_i drops in WAIT without ready: return to IDLE; the request was withdrawn.
- ERROR is terminal until rst. mem_timeout_o = 1 and freeze stays held.
- A ready arriving in the same cycle as timeout expiry wins: the FSM goes to IDLE.
- mem_busy_o = (state != IDLE).

Reset:
- Async rst drives state IDLE, wait_cnt 0, mem_timeout_o 0 and counters 0, mid-wait included.
- Combinational outputs follow inputs under reset.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs perf_lw_stall_o, perf_flush_o and perf_mem_wait_o, each CNT_WIDTH wide. They count cycles of lw_stall&!freeze, pc_src_e_i&!freeze and freeze respectively. Counters wrap modulo 2^CNT_WIDTH and clear on rst.
- When undefined, the ports and registers are absent and the remaining behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - typedef fwd_sel_e {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10}
  - typedef mem_wait_state_e {MW_IDLE, MW_WAIT, MW_ERROR}
  - constant RESULT_SRC_MEM = 2'b01
- One sub-module is natural: hazard_mem_wait_fsm, containing the FSM, wait_cnt and timeout logic. It exports freeze, mem_busy_o and mem_timeout_o.

Test Plan:
- Forwarding: rd_m=5 with reg_write_m=1, rd_w=5 with reg_write_w=1, rs1_e=5 -> forward_a=10. With rd_m=0 -> forward_a=01. With rs2_e=0, rd_m=0, rd_w=0 -> forward_b=00.
- Load-use: result_src_e=01, rd_e=7, rs2_d=7, pc_src_e=0 -> stall_f=stall_d=flush_e=1, flush_d=0. Same with pc_src_e=1 -> stall_f=stall_d=0, flush_d=flush_e=1.
- Memory wait: mem_req=1 with ready low for 3 cycles, then high -> all stalls=1 and flushes=0 for 3 cycles, mem_busy=1 from cycle 2, IDLE after the ready cycle. A branch pending during freeze is flushed only after the release.
- Timeout: MEM_TIMEOUT=4, ready held low -> ERROR after 5 not-ready cycles and mem_timeout_o=1, still 1 after ready rises. Assert rst mid-ERROR -> IDLE and mem_timeout_o=0 immediately (async).
- Boundary: ready rises exactly in the expiry cycle -> IDLE, mem_timeout_o stays 0.
- With HAZARD_PERF_CNT_EN: 2 load-use cycles, 1 branch and 3 wait cycles -> perf counters read 2, 1 and 3.
